// File: rtl/noc_pkg.sv
// Shared router types: port count, port index, port names and per-output allocator state.
// Pure declarations; no timing and no handshake.
package noc_pkg;

  localparam int NUM_PORTS = 7;

  typedef logic [$clog2(NUM_PORTS)-1:0] port_idx_t;

  typedef enum port_idx_t {
    LOCAL,
    N,
    E,
    S,
    W,
    UP,
    DN
  } port_e;

  typedef struct packed {
    logic      locked;
    port_idx_t owner;
    port_idx_t rr_ptr;
  } sa_out_state_t;

endpackage

// File: rtl/switch_allocator_if.sv
// Request/grant bundle between the input buffers and the switch allocator.
// Combinational path: grant/sel follow req_* and out_ready in the same cycle.
interface switch_allocator_if
  import noc_pkg::*;
#(
  parameter int NP = NUM_PORTS
);
  localparam int IW = $clog2(NP);

  logic [NP-1:0]         req_valid;
  logic [NP-1:0][IW-1:0] req_port;
  logic [NP-1:0]         req_tail;
  logic [NP-1:0]         out_ready;
  logic [NP-1:0]         grant;
  logic [NP-1:0][IW-1:0] sel;
  logic [NP-1:0]         sel_valid;
  logic                  err_bad_port;

  modport master (
    output req_valid, req_port, req_tail, out_ready,
    input  grant, sel, sel_valid, err_bad_port
  );

  modport slave (
    input  req_valid, req_port, req_tail, out_ready,
    output grant, sel, sel_valid, err_bad_port
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or after ptr, wrapping.
// Latency: combinational. Backpressure: caller masks req when the resource is busy.
module rr_arbiter #(
  parameter int N  = 7,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  int   idx;
  logic found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/switch_allocator.sv
// Switch allocator: per-output round-robin with wormhole locks; optional SA_STATS_EN conflict counters.
// Latency: grants combinational, state at the edge. Backpressure: out_ready=0 freezes that output.
module switch_allocator
  import noc_pkg::*;
#(
  parameter int INPUTS = NUM_PORTS
`ifdef SA_STATS_EN
  ,
  parameter int STAT_W = 16
`endif
) (
  input  logic clk,
  input  logic rst_n,
  switch_allocator_if.slave sa
`ifdef SA_STATS_EN
  ,
  output logic [INPUTS-1:0][STAT_W-1:0] conflict_cnt
`endif
);

  localparam int IDXW = $clog2(INPUTS);

  sa_out_state_t     st_q    [INPUTS];
  sa_out_state_t     st_d    [INPUTS];
  logic [INPUTS-1:0] cand    [INPUTS];
  logic [INPUTS-1:0] arb_req [INPUTS];
  logic [INPUTS-1:0] arb_gnt [INPUTS];
  logic [INPUTS-1:0] out_gnt [INPUTS];
  logic              bad_port;
  logic              err_q;

  // cand[o][i]: input i has a flit for output o; out-of-range ports match nothing
  always_comb begin
    for (int o = 0; o < INPUTS; o++) begin
      cand[o] = '0;
      for (int i = 0; i < INPUTS; i++) begin
        cand[o][i] = sa.req_valid[i] && (sa.req_port[i] == IDXW'(o));
      end
      arb_req[o] = (!st_q[o].locked && sa.out_ready[o]) ? cand[o] : '0;
    end
  end

  always_comb begin
    bad_port = 1'b0;
    for (int i = 0; i < INPUTS; i++) begin
      if (sa.req_valid[i] && (int'(sa.req_port[i]) >= INPUTS)) bad_port = 1'b1;
    end
  end

  for (genvar o = 0; o < INPUTS; o++) begin : g_arb
    rr_arbiter #(
      .N  (INPUTS),
      .IW (IDXW)
    ) u_arb (
      .req (arb_req[o]),
      .ptr (st_q[o].rr_ptr),
      .gnt (arb_gnt[o])
    );
  end

  // Locked outputs bypass the arbiter and serve only their owner
  always_comb begin
    for (int o = 0; o < INPUTS; o++) begin
      out_gnt[o] = '0;
      if (rst_n && sa.out_ready[o]) begin
        if (st_q[o].locked) begin
          if (cand[o][st_q[o].owner]) out_gnt[o][st_q[o].owner] = 1'b1;
        end else begin
          out_gnt[o] = arb_gnt[o];
        end
      end
    end
  end

  always_comb begin
    sa.grant     = '0;
    sa.sel       = '0;
    sa.sel_valid = '0;
    for (int o = 0; o < INPUTS; o++) begin
      sa.sel_valid[o] = |out_gnt[o];
      for (int i = 0; i < INPUTS; i++) begin
        if (out_gnt[o][i]) begin
          sa.grant[i] = 1'b1;
          sa.sel[o]   = IDXW'(i);
        end
      end
    end
  end

  assign sa.err_bad_port = err_q;

  always_comb begin
    for (int o = 0; o < INPUTS; o++) begin
      st_d[o] = st_q[o];
      if (sa.sel_valid[o]) begin
        if (!st_q[o].locked) begin
          st_d[o].rr_ptr = (sa.sel[o] == IDXW'(INPUTS - 1)) ? '0 : sa.sel[o] + 1'b1;
          if (!sa.req_tail[sa.sel[o]]) begin
            st_d[o].locked = 1'b1;
            st_d[o].owner  = sa.sel[o];
          end
        end else if (sa.req_tail[sa.sel[o]]) begin
          st_d[o].locked = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int o = 0; o < INPUTS; o++) st_q[o] <= '0;
      err_q <= 1'b0;
    end else begin
      for (int o = 0; o < INPUTS; o++) st_q[o] <= st_d[o];
      err_q <= err_q | bad_port;
    end
  end

`ifdef SA_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt <= '0;
    end else begin
      for (int o = 0; o < INPUTS; o++) begin
        if ((|(cand[o] & ~out_gnt[o])) && (conflict_cnt[o] != '1)) begin
          conflict_cnt[o] <= conflict_cnt[o] + 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_switch_allocator.sv
// Bench for switch_allocator: directed scenarios with literal expectations plus a long randomized run,
// all checked every cycle against a per-output lock/pointer model.
module tb_switch_allocator;
  import noc_pkg::*;

  localparam int NP = NUM_PORTS;
  localparam int IW = $clog2(NP);

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  switch_allocator_if #(.NP(NP)) sa_if ();

`ifdef SA_STATS_EN
  logic [NP-1:0][15:0] conflict_cnt;
`endif

  switch_allocator dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sa    (sa_if)
`ifdef SA_STATS_EN
    ,
    .conflict_cnt (conflict_cnt)
`endif
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one lock flag, owner and pointer per output, as plain integers
  int          m_lock [NP];
  int          m_own  [NP];
  int          m_ptr  [NP];
  int          m_cnt  [NP];
  bit          m_err;
  logic [NP-1:0] m_grant;
  bit          cmp_en = 1'b0;

  always @(negedge clk) begin
    logic [NP-1:0]         eg;
    logic [NP-1:0]         ev;
    logic [NP-1:0][IW-1:0] es;
    int win;
    int w;
    bit bad;
    if (cmp_en) begin
      eg = '0;
      ev = '0;
      es = '0;
      if (!rst_n) begin
        for (int o = 0; o < NP; o++) begin
          m_lock[o] = 0; m_own[o] = 0; m_ptr[o] = 0; m_cnt[o] = 0;
        end
        m_err = 1'b0;
      end else begin
        for (int o = 0; o < NP; o++) begin
          win = -1;
          if (sa_if.out_ready[o]) begin
            if (m_lock[o] != 0) begin
              if (sa_if.req_valid[m_own[o]] && sa_if.req_port[m_own[o]] == o) win = m_own[o];
            end else begin
              for (int k = 0; k < NP; k++) begin
                w = (m_ptr[o] + k) % NP;
                if (win < 0 && sa_if.req_valid[w] && sa_if.req_port[w] == o) win = w;
              end
            end
          end
          if (win >= 0) begin
            eg[win] = 1'b1;
            ev[o]   = 1'b1;
            es[o]   = IW'(win);
          end
        end
      end
      m_grant = eg;
      chk("grant", 32'(sa_if.grant), 32'(eg));
      chk("sel_valid", 32'(sa_if.sel_valid), 32'(ev));
      chk("sel", 32'(sa_if.sel), 32'(es));
      chk("err_bad_port", 32'(sa_if.err_bad_port), 32'(m_err));
`ifdef SA_STATS_EN
      for (int o = 0; o < NP; o++) chk("conflict_cnt", 32'(conflict_cnt[o]), 32'(m_cnt[o]));
`endif
      if (rst_n) begin
        for (int o = 0; o < NP; o++) begin
          if (ev[o]) begin
            w = int'(es[o]);
            if (m_lock[o] == 0) begin
              m_ptr[o] = (w + 1) % NP;
              if (!sa_if.req_tail[w]) begin
                m_lock[o] = 1;
                m_own[o]  = w;
              end
            end else if (sa_if.req_tail[w]) begin
              m_lock[o] = 0;
            end
          end
          bad = 1'b0;
          for (int i = 0; i < NP; i++) begin
            if (sa_if.req_valid[i] && sa_if.req_port[i] == o && !eg[i]) bad = 1'b1;
          end
          if (bad && m_cnt[o] < 65535) m_cnt[o] = m_cnt[o] + 1;
        end
        for (int i = 0; i < NP; i++) begin
          if (sa_if.req_valid[i] && int'(sa_if.req_port[i]) >= NP) m_err = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at();
    @(negedge clk);
    #1;
  endtask

  task automatic clear();
    sa_if.req_valid = '0;
    sa_if.req_port  = '0;
    sa_if.req_tail  = '0;
    sa_if.out_ready = '1;
  endtask

  task automatic set_req(input int i, input int p, input bit t);
    sa_if.req_valid[i] = 1'b1;
    sa_if.req_port[i]  = IW'(p);
    sa_if.req_tail[i]  = t;
  endtask

  int           rem [NP];
  logic [NP-1:0] g;

  initial begin
    rst_n = 1'b0;
    clear();
    for (int i = 0; i < NP; i++) set_req(i, i, 1'b1);
    cmp_en = 1'b1;

    // Reset: everything requested, nothing granted
    at();
    chk("rst_grant", 32'(sa_if.grant), 32'h0);
    chk("rst_sel_valid", 32'(sa_if.sel_valid), 32'h0);
    chk("rst_err", 32'(sa_if.err_bad_port), 32'h0);
    tick();
    clear();
    rst_n = 1'b1;

    // Contention: 1, 3, 5 to output 2, served in rotation from pointer 0
    set_req(1, 2, 1'b1);
    set_req(3, 2, 1'b1);
    set_req(5, 2, 1'b1);
    for (int c = 0; c < 3; c++) begin
      at();
      chk("cont_grant", 32'(sa_if.grant), 32'(1 << (1 + 2 * c)));
      chk("cont_sel2", 32'(sa_if.sel[2]), 32'(1 + 2 * c));
      chk("cont_model", 32'(m_grant), 32'(1 << (1 + 2 * c)));
      tick();
      sa_if.req_valid[1 + 2 * c] = 1'b0;
    end
    clear();

    // Wormhole: 4-flit packet from 0 holds output 4 against input 6
    set_req(0, 4, 1'b0);
    set_req(6, 4, 1'b1);
    for (int f = 0; f < 4; f++) begin
      at();
      chk("worm_in0", 32'(sa_if.grant), 32'h01);
      chk("worm_model", 32'(m_grant), 32'h01);
      tick();
      if (f == 2) sa_if.req_tail[0] = 1'b1;
      if (f == 3) sa_if.req_valid[0] = 1'b0;
    end
    at();
    chk("worm_in6", 32'(sa_if.grant), 32'h40);
    tick();
    clear();

    // Backpressure: input 2 locks output 3, then three stalled cycles
    set_req(2, 3, 1'b0);
    at();
    chk("bp_head", 32'(sa_if.grant), 32'h04);
    tick();
    sa_if.out_ready[3] = 1'b0;
    set_req(4, 3, 1'b1);
    for (int c = 0; c < 3; c++) begin
      at();
      chk("bp_stall", 32'(sa_if.grant), 32'h0);
      chk("bp_stall_selv", 32'(sa_if.sel_valid[3]), 32'h0);
      tick();
    end
    sa_if.out_ready[3] = 1'b1;
    at();
    chk("bp_resume", 32'(sa_if.grant), 32'h04);
    tick();
    sa_if.req_tail[2] = 1'b1;
    at();
    chk("bp_tail", 32'(sa_if.grant), 32'h04);
    tick();
    sa_if.req_valid[2] = 1'b0;
    at();
    chk("bp_next", 32'(sa_if.grant), 32'h10);
    tick();
    clear();

    // Parallel: input i to output (i+1)%7
    for (int i = 0; i < NP; i++) set_req(i, (i + 1) % NP, 1'b1);
    at();
    chk("par_grant", 32'(sa_if.grant), 32'h7f);
    for (int o = 0; o < NP; o++) chk("par_sel", 32'(sa_if.sel[o]), 32'((o + 6) % NP));
    tick();
    clear();

    // Bad port: never granted, error sticks
    set_req(3, 7, 1'b1);
    at();
    chk("bad_grant0", 32'(sa_if.grant), 32'h0);
    tick();
    at();
    chk("bad_grant1", 32'(sa_if.grant), 32'h0);
    chk("bad_err", 32'(sa_if.err_bad_port), 32'h1);
    tick();
    sa_if.req_valid[3] = 1'b0;
    at();
    chk("bad_sticky", 32'(sa_if.err_bad_port), 32'h1);
    tick();

    // Reset mid-packet drops the lock on output 5
    set_req(1, 5, 1'b0);
    at();
    chk("mp_head", 32'(sa_if.grant), 32'h02);
    tick();
    rst_n = 1'b0;
    at();
    chk("mp_rst_grant", 32'(sa_if.grant), 32'h0);
    chk("mp_rst_err", 32'(sa_if.err_bad_port), 32'h0);
    tick();
    rst_n = 1'b1;
    clear();
    set_req(4, 5, 1'b1);
    at();
    chk("mp_new_head", 32'(sa_if.grant), 32'h10);
    tick();
    clear();

    // Randomized traffic: packets of 1-4 flits, random destinations and readiness
    for (int i = 0; i < NP; i++) rem[i] = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      at();
      g = sa_if.grant;
      tick();
      for (int i = 0; i < NP; i++) begin
        if (sa_if.req_valid[i] && g[i]) begin
          rem[i] = rem[i] - 1;
          if (rem[i] == 0) sa_if.req_valid[i] = 1'b0;
          else sa_if.req_tail[i] = (rem[i] == 1);
        end
        if (!sa_if.req_valid[i] && $urandom_range(0, 2) == 0) begin
          rem[i] = int'($urandom_range(1, 4));
          set_req(i, int'($urandom_range(0, NP - 1)), rem[i] == 1);
        end
      end
      for (int o = 0; o < NP; o++) sa_if.out_ready[o] = ($urandom_range(0, 3) != 0);
    end

    at();
    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
